// File: rtl/regfile_scoreboard_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard_ctrl
//
// Controller that sits between decode, writeback and the write port of the
// NREG x DW register file.
//   - After reset (INIT) it walks the write port over every index, writing
//     zero, one register per cycle, for exactly NREG cycles.
//   - In RUN it forwards writeback results straight to the write port
//     (combinational, zero latency) and suppresses writes to register 0.
//   - A per-register pending scoreboard stalls decode on RAW/WAW hazards,
//     and an in-flight counter caps outstanding register writes.
//
// Ports
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   dec_valid                  decode holds an instruction
//   dec_rs / dec_rt            source indices, qualified by dec_use_rs / dec_use_rt
//   dec_writes / dec_rd        instruction writes register dec_rd
//   dec_stall / dec_issue      hold decode / instruction issues this cycle
//   wb_valid/wb_dest/wb_data   writeback result
//   rf_we/rf_waddr/rf_wdata    register file write port
//   ready                      initialisation complete
//   pending                    scoreboard bit per register
//   inflight                   outstanding write count
//   wb_err                     sticky: writeback hit a non-pending register
// ---------------------------------------------------------------------------
module regfile_scoreboard_ctrl #(
    parameter int NREG         = 32,
    parameter int AW           = 5,
    parameter int DW           = 32,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            dec_valid,
    input  logic [AW-1:0]   dec_rs,
    input  logic [AW-1:0]   dec_rt,
    input  logic            dec_use_rs,
    input  logic            dec_use_rt,
    input  logic            dec_writes,
    input  logic [AW-1:0]   dec_rd,
    output logic            dec_stall,
    output logic            dec_issue,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_dest,
    input  logic [DW-1:0]   wb_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [DW-1:0]   rf_wdata,
    output logic            ready,
    output logic [NREG-1:0] pending,
    output logic [3:0]      inflight,
    output logic            wb_err
);

    typedef enum logic {INIT, RUN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] clr_cnt;

    logic          run;
    logic          wb_wr;       // writeback targets a real (non-zero) register
    logic          rd_counted;  // destination is a real register
    logic          haz;
    logic          full;
    logic          inc;
    logic          dec;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    assign run        = (state == RUN);
    assign wb_wr      = wb_valid && (wb_dest != '0);
    assign rd_counted = dec_writes && (dec_rd != '0);

    // Hazard check uses the registered scoreboard only, so a same-cycle
    // writeback releases the stall one cycle later.
    assign haz  = (dec_use_rs && pending[dec_rs]) ||
                  (dec_use_rt && pending[dec_rt]) ||
                  (dec_writes && pending[dec_rd]);
    assign full = rd_counted && (inflight == 4'(MAX_INFLIGHT));

    assign dec_stall = dec_valid && (!ready || haz || full);
    assign dec_issue = dec_valid && !dec_stall;

    // FSM state register and clear counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= INIT;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT)
                clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // FSM next state and write-port mux
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = wb_dest;
        rf_wdata  = wb_data;
        case (state)
            INIT: begin
                rf_we    = 1'b1;
                rf_waddr = clr_cnt;
                rf_wdata = '0;
                if (clr_cnt == AW'(NREG - 1))
                    state_nxt = RUN;
            end
            RUN: begin
                ready = 1'b1;
                rf_we = wb_wr;
            end
            default: state_nxt = INIT;
        endcase
    end

    // Issue implies RUN, so no extra qualification is needed on the set side.
    assign inc     = dec_issue && rd_counted;
    assign dec     = run && wb_wr && pending[wb_dest];
    assign set_vec = inc ? (NREG'(1) << dec_rd) : '0;
    assign clr_vec = (run && wb_wr) ? (NREG'(1) << wb_dest) : '0;

    // Scoreboard, in-flight counter and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            inflight <= '0;
            wb_err   <= 1'b0;
        end else begin
            // OR-ing the set after masking the clear makes set win on a collision.
            pending <= (pending & ~clr_vec) | set_vec;
            case ({inc, dec})
                2'b10:   inflight <= inflight + 4'd1;
                2'b01:   if (inflight != 4'd0) inflight <= inflight - 4'd1;
                default: inflight <= inflight;
            endcase
            if (run && wb_wr && !pending[wb_dest])
                wb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard_ctrl
//
// Scoreboard bench: every stimulus cycle computes the expected outputs from a
// reference model (outstanding writes kept as a queue of register numbers)
// and pushes them; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_regfile_scoreboard_ctrl;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int MAXI = 4;

    logic            clk;
    logic            reset;
    logic            dec_valid;
    logic [AW-1:0]   dec_rs;
    logic [AW-1:0]   dec_rt;
    logic            dec_use_rs;
    logic            dec_use_rt;
    logic            dec_writes;
    logic [AW-1:0]   dec_rd;
    logic            dec_stall;
    logic            dec_issue;
    logic            wb_valid;
    logic [AW-1:0]   wb_dest;
    logic [DW-1:0]   wb_data;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic            ready;
    logic [NREG-1:0] pending;
    logic [3:0]      inflight;
    logic            wb_err;

    regfile_scoreboard_ctrl #(
        .NREG(NREG), .AW(AW), .DW(DW), .MAX_INFLIGHT(MAXI)
    ) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt),
        .dec_writes(dec_writes), .dec_rd(dec_rd),
        .dec_stall(dec_stall), .dec_issue(dec_issue),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .ready(ready), .pending(pending), .inflight(inflight), .wb_err(wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        stall;
        logic        issue;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pend;
        logic [3:0]  infl;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Reference model: initialisation progress, list of registers with an
    // outstanding write, and the sticky error flag.
    bit m_run;
    int m_idx;
    int m_q[$];
    bit m_err;

    function automatic bit m_pend(input int r);
        foreach (m_q[i]) if (m_q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ready",     32'(ready),     32'(e.rdy));
            chk("dec_stall", 32'(dec_stall), 32'(e.stall));
            chk("dec_issue", 32'(dec_issue), 32'(e.issue));
            chk("rf_we",     32'(rf_we),     32'(e.we));
            if (e.we) begin
                chk("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
                chk("rf_wdata", rf_wdata,      e.wdata);
            end
            chk("pending",   pending,        e.pend);
            chk("inflight",  32'(inflight),  32'(e.infl));
            chk("wb_err",    32'(wb_err),    32'(e.err));
        end
    end

    // One stimulus cycle: drive, predict, push, advance model at the edge.
    task automatic cyc(input logic rst, input logic dv,
                       input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt,
                       input logic wr, input logic [4:0] rd,
                       input logic wbv, input logic [4:0] wbd,
                       input logic [31:0] wbdat);
        exp_t e;
        bit   haz, full, stall, issue;
        reset = rst; dec_valid = dv;
        dec_rs = rs; dec_use_rs = urs; dec_rt = rt; dec_use_rt = urt;
        dec_writes = wr; dec_rd = rd;
        wb_valid = wbv; wb_dest = wbd; wb_data = wbdat;

        haz   = (urs && m_pend(int'(rs))) || (urt && m_pend(int'(rt))) ||
                (wr && m_pend(int'(rd)));
        full  = wr && (rd != 0) && (m_q.size() == MAXI);
        stall = dv && (!m_run || haz || full);
        issue = dv && !stall;
        e.rdy   = m_run;
        e.stall = stall;
        e.issue = issue;
        if (!m_run) begin
            e.we = 1'b1; e.waddr = m_idx[4:0]; e.wdata = 32'h0;
        end else begin
            e.we = wbv && (wbd != 0); e.waddr = wbd; e.wdata = wbdat;
        end
        e.pend = 32'h0;
        foreach (m_q[i]) e.pend[m_q[i]] = 1'b1;
        e.infl = 4'(m_q.size());
        e.err  = m_err;
        exp_q.push_back(e);

        @(posedge clk);
        if (rst) begin
            m_run = 1'b0; m_idx = 0; m_q.delete(); m_err = 1'b0;
        end else if (!m_run) begin
            m_idx++;
            if (m_idx == NREG) m_run = 1'b1;
        end else begin
            if (wbv && wbd != 0) begin
                if (m_pend(int'(wbd))) begin
                    foreach (m_q[i]) if (m_q[i] == int'(wbd)) begin
                        m_q.delete(i);
                        break;
                    end
                end else begin
                    m_err = 1'b1;
                end
            end
            if (issue && wr && rd != 0) m_q.push_back(int'(rd));
        end
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic rnd_cycle();
        logic       rst, dv, wbv;
        logic [4:0] wbd;
        rst = ($urandom_range(399) == 0);
        dv  = ($urandom_range(9) < 7);
        wbv = ($urandom_range(9) < 4);
        if (m_q.size() > 0 && $urandom_range(19) != 0)
            wbd = 5'(m_q[$urandom_range(m_q.size() - 1)]);
        else
            wbd = 5'($urandom_range(15));
        cyc(rst, dv, 5'($urandom_range(7)), 1'($urandom), 5'($urandom_range(7)), 1'($urandom),
            1'($urandom), 5'($urandom_range(7)), wbv, wbd, $urandom);
    endtask

    initial begin
        reset = 1'b1; dec_valid = 0; dec_rs = 0; dec_rt = 0; dec_use_rs = 0;
        dec_use_rt = 0; dec_writes = 0; dec_rd = 0; wb_valid = 0; wb_dest = 0;
        wb_data = 0;
        m_run = 1'b0; m_idx = 0; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Initialisation sweep with decode held valid, then first RUN cycle
        repeat (32) cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, 5'd3, 32'h1234);
        idle();

        // RAW on r5, released one cycle after its writeback
        cyc(0, 1, 0, 0, 0, 0, 1, 5'd5, 0, 0, 32'h0);
        cyc(0, 1, 5'd5, 1, 0, 0, 0, 0, 0, 0, 32'h0);
        cyc(0, 1, 5'd5, 1, 0, 0, 0, 0, 0, 0, 32'h0);
        cyc(0, 1, 5'd5, 1, 0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        cyc(0, 1, 5'd5, 1, 0, 0, 0, 0, 0, 0, 32'h0);

        // In-flight limit
        for (int r = 1; r <= 4; r++) cyc(0, 1, 0, 0, 0, 0, 1, 5'(r), 0, 0, 32'h0);
        cyc(0, 1, 0, 0, 0, 0, 1, 5'd6, 0, 0, 32'h0);
        cyc(0, 1, 0, 0, 0, 0, 1, 5'd6, 0, 0, 32'h0);
        cyc(0, 1, 0, 0, 0, 0, 1, 5'd6, 1, 5'd2, 32'h22);
        cyc(0, 1, 0, 0, 0, 0, 1, 5'd6, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd1, 32'h11);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 32'h33);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd4, 32'h44);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd6, 32'h66);

        // Register 0: never pending, never counted, never written
        cyc(0, 1, 5'd0, 1, 5'd0, 1, 1, 5'd0, 1, 5'd0, 32'hFFFF);
        cyc(0, 1, 5'd0, 1, 5'd0, 1, 1, 5'd0, 0, 0, 32'h0);

        // Writeback to a non-pending register
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 32'h99);
        idle();
        idle();

        // Reset in RUN with pending set, then at initialisation index 17
        cyc(0, 1, 0, 0, 0, 0, 1, 5'd7, 0, 0, 32'h0);
        cyc(0, 1, 0, 0, 0, 0, 1, 5'd8, 0, 0, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        repeat (17) idle();
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        repeat (33) idle();

        // Randomised traffic
        repeat (3000) rnd_cycle();

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard_ctrl.md
Name: regfile_scoreboard_ctrl

Overview:
Controller in front of the 32x32 register file.
- After reset it sequences the file's write port to zero all registers.
- It then owns the write port and forwards writeback traffic to it.
- A per-register pending scoreboard stalls decode on RAW and WAW hazards, and an in-flight limit caps outstanding writes.
- It sits between the decode stage, the writeback stage and the register file's write inputs.

Parameters:
NREG, 32, number of architectural registers (power of two)
AW, 5, register index width, log2(NREG)
DW, 32, data width
MAX_INFLIGHT, 4, maximum outstanding register writes (1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, synchronous, active-high
dec_valid  in  1  decode holds an instruction
dec_rs  in  AW  source index A
dec_rt  in  AW  source index B
dec_use_rs  in  1  instruction reads rs
dec_use_rt  in  1  instruction reads rt
dec_writes  in  1  instruction will write a register
dec_rd  in  AW  destination index
dec_stall  out  1  hold decode this cycle
dec_issue  out  1  instruction issues this cycle
wb_valid  in  1  writeback result present
wb_dest  in  AW  writeback destination
wb_data  in  DW  writeback data
rf_we  out  1  register file write enable
rf_waddr  out  AW  register file write index
rf_wdata  out  DW  register file write data
ready  out  1  init complete
pending  out  NREG  scoreboard bit vector
inflight  out  4  outstanding write count
wb_err  out  1  sticky: writeback to non-pending register

Behaviour:
- States: INIT, RUN.
- On reset: state=INIT, clear counter=0, pending=0, inflight=0, wb_err=0, ready=0.
- INIT:
  - rf_we=1, rf_waddr=clear counter, rf_wdata=0.
  - Counter increments each cycle; after writing index NREG-1 the FSM enters RUN.
  - INIT lasts exactly NREG cycles.
  - dec_stall=1, dec_issue=0.
  - wb_valid is ignored: no write, no error.
- RUN:
  - ready=1.
  - rf_we = wb_valid && wb_dest!=0; rf_waddr=wb_dest; rf_wdata=wb_data. Purely combinational, zero latency.
  - Writes to register 0 are suppressed in RUN.
- Hazard: haz = (dec_use_rs && pending[dec_rs]) || (dec_use_rt && pending[dec_rt]) || (dec_writes && pending[dec_rd]).
  - Registered pending is used. A writeback in the same cycle does NOT release the hazard; the stall lasts one cycle past the writeback.
- Capacity: full = dec_writes && dec_rd!=0 && inflight==MAX_INFLIGHT.
- dec_stall = dec_valid && (!ready || haz || full); dec_issue = dec_valid && !dec_stall.
- Register 0 is never pending. Reads of r0 never stall; writes to r0 never count toward inflight.
- Scoreboard update at clock edge in RUN:
  - Issue with dec_writes && dec_rd!=0: set pending[dec_rd].
  - wb_valid && wb_dest!=0: clear pending[wb_dest].
  - Same register set and cleared in one cycle: set wins. This is unreachable under the WAW stall but is required anyway.
- inflight:
  - +1 on counted issue, -1 on wb_valid with wb_dest!=0 and pending[wb_dest]=1.
  - Both events in one cycle: unchanged.
  - Never wraps: a decrement at 0 is ignored.
- wb_err is set when wb_valid && wb_dest!=0 && !pending[wb_dest] in RUN. It is then sticky until reset, and the write still occurs.
- Reset asserted mid-INIT or mid-RUN restarts INIT from index 0 and clears all state on the next edge.

Test Plan:
- Reset then idle → rf_we=1 for exactly 32 cycles with rf_waddr 0..31 and rf_wdata=0; ready rises in cycle 33; dec_valid held high has dec_stall=1 throughout INIT.
- Issue writes r5, then next cycle decode reads rs=5 → dec_stall=1 until the cycle after wb_valid with wb_dest=5 (data 0xDEADBEEF); rf_we=1, rf_waddr=5 on the wb cycle; pending[5] then clears.
- Issue 4 writes to r1..r4 with no writeback, then a 5th to r6 → 5th stalls with inflight=4; one writeback to r2 → 5th issues the following cycle and inflight stays 4.
- Writes to r0 and reads of r0 → never stall, pending[0]=0, inflight unchanged; wb_valid with wb_dest=0 gives rf_we=0.
- wb_valid to r9 while not pending → wb_err=1 and stays 1; rf_we=1 with rf_waddr=9.
- Assert reset for one cycle at INIT index 17 and in RUN with pending!=0 → INIT restarts at index 0; pending=0, inflight=0, wb_err=0.
